pixel_stream_fifo: RTL and testbench

- Elastic buffer between the colour LUT stage (depth result -> RGB) and the AXI-Stream pixel packer.
- Decouples the iterative depth engine from output back-pressure, so the engine can start the next pixel while the packer is stalled.
- Carries the sof/eol sideband with each pixel.
- Checks frame geometry on the fly and raises sticky error flags for the overlay to poll.

---
 rtl/pixel_stream_fifo.sv | 144 ++++++++++++++
 tb/tb_pixel_stream_fifo.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_stream_fifo.sv
// Elastic pixel buffer between the colour LUT and the AXI-Stream packer.
// Registered first-word-fall-through head, sof/eol sideband, sticky frame-geometry error flags.
module pixel_stream_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 24,
    parameter int X_SIZE = 640,
    parameter int Y_SIZE = 480
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_sof,
    input  logic                     in_eol,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_sof,
    output logic                     out_eol,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     err_line,
    output logic                     err_frame,
    input  logic                     err_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = DATA_W + 2;
    localparam int XW = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
    localparam int YW = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;

    logic [EW-1:0] mem_q [DEPTH];
    logic [AW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]   level_q, level_d;
    logic [EW-1:0] head_q, head_d;
    logic          out_valid_q, out_valid_d;
    logic          in_ready_q, in_ready_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          err_line_q, err_line_d;
    logic          err_frame_q, err_frame_d;

    logic push, pop, head_load, arr_empty, to_array, x_last, y_last;

    assign push      = in_valid & in_ready_q;
    assign pop       = out_valid_q & out_ready;
    assign head_load = !out_valid_q | out_ready;
    assign arr_empty = (wptr_q == rptr_q);
    // A write that finds both the array and the head free goes straight into the head.
    assign to_array  = push & !(head_load & arr_empty);
    assign x_last    = (x_q == XW'(X_SIZE - 1));
    assign y_last    = (y_q == YW'(Y_SIZE - 1));

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        head_d      = head_q;
        out_valid_d = out_valid_q;
        if (to_array) begin
            wptr_d = wptr_q + (AW+1)'(1);
        end
        if (head_load) begin
            if (!arr_empty) begin
                head_d      = mem_q[rptr_q[AW-1:0]];
                rptr_d      = rptr_q + (AW+1)'(1);
                out_valid_d = 1'b1;
            end else if (push) begin
                head_d      = {in_sof, in_eol, in_data};
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end
        level_d    = level_q + (AW+1)'(push) - (AW+1)'(pop);
        in_ready_d = (level_d != (AW+1)'(DEPTH));
    end

    always_comb begin
        x_d         = x_q;
        y_d         = y_q;
        err_line_d  = err_clr ? 1'b0 : err_line_q;
        err_frame_d = err_clr ? 1'b0 : err_frame_q;
        if (push) begin
            if (in_eol != x_last) begin
                err_line_d = 1'b1;
            end
            if (in_sof != ((x_q == '0) && (y_q == '0))) begin
                err_frame_d = 1'b1;
            end
            // sof resynchronises the checker so the following pixel is x=1 of line 0.
            if (in_sof) begin
                x_d = XW'(1);
                y_d = '0;
            end else if (x_last) begin
                x_d = '0;
                y_d = y_last ? '0 : y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (to_array) begin
            mem_q[wptr_q[AW-1:0]] <= {in_sof, in_eol, in_data};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            level_q     <= '0;
            head_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            x_q         <= '0;
            y_q         <= '0;
            err_line_q  <= 1'b0;
            err_frame_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            level_q     <= level_d;
            head_q      <= head_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            x_q         <= x_d;
            y_q         <= y_d;
            err_line_q  <= err_line_d;
            err_frame_q <= err_frame_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sof   = head_q[EW-1];
    assign out_eol   = head_q[EW-2];
    assign out_data  = head_q[DATA_W-1:0];
    assign level     = level_q;
    assign err_line  = err_line_q;
    assign err_frame = err_frame_q;

endmodule

// File: tb/tb_pixel_stream_fifo.sv
// Bench for pixel_stream_fifo: queue-based occupancy/stream model checked every negedge,
// plus directed scenarios with literal expectations. Frame geometry is shrunk to 8x4.
module tb_pixel_stream_fifo;

    localparam int DEPTH = 16;
    localparam int DW    = 24;
    localparam int XS    = 8;
    localparam int YS    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, in_sof, in_eol;
    logic [DW-1:0] in_data;
    logic          out_valid, out_ready, out_sof, out_eol;
    logic [DW-1:0] out_data;
    logic [4:0]    level;
    logic          err_line, err_frame, err_clr;

    pixel_stream_fifo #(.DEPTH(DEPTH), .DATA_W(DW), .X_SIZE(XS), .Y_SIZE(YS)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sof(in_sof), .in_eol(in_eol),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sof(out_sof), .out_eol(out_eol),
        .level(level), .err_line(err_line), .err_frame(err_frame), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            if (miscompares <= 40)
                $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
        end
    endtask

    // Model: the FIFO is just an ordered list of at most DEPTH pixels; the head is its front.
    logic [25:0] mq[$];
    int          mpos;
    bit          m_el, m_ef;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            mpos = 0;
            m_el = 0;
            m_ef = 0;
        end else begin
            bit pu, po, nl, nf;
            pu = in_valid && (mq.size() < DEPTH);
            po = out_ready && (mq.size() > 0);
            nl = err_clr ? 1'b0 : m_el;
            nf = err_clr ? 1'b0 : m_ef;
            if (pu) begin
                if (in_eol != ((mpos % XS) == XS - 1)) nl = 1;
                if (in_sof != (mpos == 0)) nf = 1;
                mpos = in_sof ? 1 : (mpos + 1) % (XS * YS);
            end
            m_el = nl;
            m_ef = nf;
            if (po) void'(mq.pop_front());
            if (pu) mq.push_back({in_sof, in_eol, in_data});
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("level", level, mq.size());
            chk("out_valid", out_valid, mq.size() > 0);
            chk("in_ready", in_ready, mq.size() < DEPTH);
            chk("err_line", err_line, m_el);
            chk("err_frame", err_frame, m_ef);
            if (mq.size() > 0) begin
                chk("out_data", out_data, mq[0][23:0]);
                chk("out_sof", out_sof, mq[0][25]);
                chk("out_eol", out_eol, mq[0][24]);
            end
        end
    end

    // Stimulus-side frame position, used to generate correct sof/eol.
    int gpos = 0;

    task automatic cyc(input bit v, input logic [DW-1:0] d, input bit bad, input bit clr,
                       input bit ordy, output bit acc, output bit pop, output logic [DW-1:0] pd);
        in_valid  = v;
        in_data   = d;
        in_sof    = (gpos == 0);
        in_eol    = ((gpos % XS) == XS - 1) ^ bad;
        err_clr   = clr;
        out_ready = ordy;
        acc = v && in_ready;
        pop = out_valid && ordy;
        pd  = out_data;
        @(posedge clk);
        #1;
        if (acc) gpos = (gpos + 1) % (XS * YS);
        in_valid = 1'b0;
        err_clr  = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit acc, pop;
        logic [DW-1:0] pd;
        logic [DW-1:0] rec[$];
        logic [DW-1:0] sent[$];
        int pops, n, guard;

        rst = 1'b1; in_valid = 0; in_data = '0; in_sof = 0; in_eol = 0;
        out_ready = 0; err_clr = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_level", level, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_err", {err_line, err_frame}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // single pixel, stalled output
        cyc(1, 24'hA1B2C3, 0, 0, 0, acc, pop, pd);
        @(negedge clk);
        chk("t1_valid", out_valid, 1);
        chk("t1_data", out_data, 24'hA1B2C3);
        chk("t1_sof", out_sof, 1);
        chk("t1_level", level, 1);
        for (int i = 0; i < 10; i++) cyc(0, '0, 0, 0, 0, acc, pop, pd);
        chk("t1_stall_data", out_data, 24'hA1B2C3);
        cyc(0, '0, 0, 0, 1, acc, pop, pd);

        // fill to capacity, then drain
        for (int i = 0; i < 16; i++) cyc(1, DW'(i), 0, 0, 0, acc, pop, pd);
        @(negedge clk);
        chk("t2_full_level", level, 16);
        chk("t2_full_ready", in_ready, 0);
        cyc(1, 24'hDEAD, 0, 0, 0, acc, pop, pd);
        chk("t2_17th_rejected", acc, 0);
        @(negedge clk);
        chk("t2_level_after_17", level, 16);
        for (int i = 0; i < 20; i++) begin
            cyc(0, '0, 0, 0, 1, acc, pop, pd);
            if (pop) rec.push_back(pd);
        end
        chk("t2_drain_count", rec.size(), 16);
        if (rec.size() == 16) begin
            chk("t2_first", rec[0], 0);
            chk("t2_last", rec[15], 15);
        end
        chk("t2_empty", level, 0);

        // continuous streaming
        pops = 0;
        for (int i = 0; i < 2000; i++) begin
            cyc(1, DW'(i + 100), 0, 0, 1, acc, pop, pd);
            if (pop) pops++;
        end
        chk("t3_pops", pops, 1999);
        @(negedge clk);
        chk("t3_level", level, 1);
        for (int i = 0; i < 4; i++) cyc(0, '0, 0, 0, 1, acc, pop, pd);

        // random handshakes over two frames
        sent.delete(); rec.delete(); n = 0; guard = 0;
        while (n < 2 * XS * YS && guard < 3000) begin
            logic [DW-1:0] d;
            d = DW'($urandom);
            cyc(bit'($urandom_range(0, 1)), d, 0, 0, bit'($urandom_range(0, 1)), acc, pop, pd);
            if (acc) begin sent.push_back(d); n++; end
            if (pop) rec.push_back(pd);
            guard++;
        end
        chk("t4_budget", guard < 3000, 1);
        for (int i = 0; i < 40; i++) begin
            cyc(0, '0, 0, 0, 1, acc, pop, pd);
            if (pop) rec.push_back(pd);
        end
        chk("t4_stream", rec == sent, 1);
        chk("t4_errs", {err_line, err_frame}, 0);

        // bad eol at x = XS-2
        guard = 0;
        while ((gpos % XS) != XS - 2 && guard < 40) begin
            cyc(1, 24'h111111, 0, 0, 1, acc, pop, pd);
            guard++;
        end
        chk("t5_align", gpos % XS, XS - 2);
        cyc(1, 24'h222222, 1, 0, 1, acc, pop, pd);
        @(negedge clk);
        chk("t5_err_set", err_line, 1);
        for (int i = 0; i < 5; i++) cyc(0, '0, 0, 0, 1, acc, pop, pd);
        chk("t5_err_sticky", err_line, 1);
        cyc(0, '0, 0, 1, 1, acc, pop, pd);
        @(negedge clk);
        chk("t5_err_cleared", err_line, 0);
        cyc(1, 24'h333333, 1, 0, 1, acc, pop, pd);
        cyc(1, 24'h444444, 1, 1, 1, acc, pop, pd);
        @(negedge clk);
        chk("t5_set_beats_clr", err_line, 1);
        chk("t5_frame_ok", err_frame, 0);
        cyc(0, '0, 0, 1, 1, acc, pop, pd);

        // reset mid-stream
        for (int i = 0; i < 8; i++) cyc(1, DW'(24'h700 + i), 0, 0, 0, acc, pop, pd);
        @(negedge clk);
        chk("t6_loaded", level, 8);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_level", level, 0);
        chk("t6_rst_valid", out_valid, 0);
        gpos = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc(1, 24'h000055, 0, 0, 0, acc, pop, pd);
        @(negedge clk);
        chk("t6_valid", out_valid, 1);
        chk("t6_data", out_data, 24'h000055);
        chk("t6_level", level, 1);
        cyc(0, '0, 0, 0, 1, acc, pop, pd);
        @(negedge clk);
        chk("t6_no_stale", out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
